// File: rtl/ram_arbiter.sv
// ram_arbiter: latched-grant arbiter for one single-ported RAM.
// Sources are N instruction fetch ports (served round-robin) and one data port.
// The data port has priority, but a streak limit guarantees that a waiting fetch
// is eventually served. Once granted, an owner keeps the RAM until its access
// completes (ramstate==ACCESS) or until it drops its request (abort).
// Optional feature macro: ARB_PERF_CNT_EN adds the dgrant_cnt, igrant_cnt and
// starve_cnt performance counter outputs.
module ram_arbiter #(
    parameter int CPUS        = 2,
    parameter int MAX_DSTREAK = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [CPUS-1:0]           iREN,
    input  logic [CPUS-1:0][31:0]     iaddr,
    output logic [CPUS-1:0]           iwait,
    output logic [CPUS-1:0][31:0]     iload,
    input  logic                      dREN,
    input  logic                      dWEN,
    input  logic [31:0]               daddr,
    input  logic [31:0]               dstore,
    output logic                      dwait,
    output logic [31:0]               dload,
    output logic                      ramREN,
    output logic                      ramWEN,
    output logic [31:0]               ramaddr,
    output logic [31:0]               ramstore,
    input  logic [31:0]               ramload,
    input  logic [1:0]                ramstate
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]               dgrant_cnt,
    output logic [31:0]               igrant_cnt,
    output logic [15:0]               starve_cnt
`endif
);

    localparam int OW = (CPUS > 1) ? $clog2(CPUS) : 1;

    localparam logic [1:0]    RS_ACCESS    = 2'd2;
    localparam logic [3:0]    STREAK_MAX_C = 4'(MAX_DSTREAK);
    localparam logic [OW-1:0] LAST_CPU_C   = OW'(CPUS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_D = 2'd1,
        GNT_I = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] own_q, own_d;
    logic [OW-1:0] rr_ptr_q, rr_ptr_d;
    logic [3:0]    dstreak_q, dstreak_d;

`ifdef ARB_PERF_CNT_EN
    logic [31:0]   dgrant_cnt_q, dgrant_cnt_d;
    logic [31:0]   igrant_cnt_q, igrant_cnt_d;
    logic [15:0]   starve_cnt_q, starve_cnt_d;
`endif

    logic          d_req_s;
    logic          any_i_s;
    logic          ram_access_s;
    logic [OW-1:0] rr_pick_s;
    logic          rr_found_s;
    int            rr_idx_s;

    assign d_req_s      = dREN | dWEN;
    assign any_i_s      = |iREN;
    assign ram_access_s = (ramstate == RS_ACCESS);

    // Round-robin pick: first pending fetch at or after rr_ptr, wrapping modulo CPUS.
    always_comb begin
        rr_pick_s  = rr_ptr_q;
        rr_found_s = 1'b0;
        rr_idx_s   = 0;
        for (int i = 0; i < CPUS; i++) begin
            rr_idx_s = int'(rr_ptr_q) + i;
            if (rr_idx_s >= CPUS) begin
                rr_idx_s = rr_idx_s - CPUS;
            end else begin
                rr_idx_s = rr_idx_s;
            end
            if (!rr_found_s && iREN[rr_idx_s]) begin
                rr_found_s = 1'b1;
                rr_pick_s  = OW'(rr_idx_s);
            end else begin
                rr_found_s = rr_found_s;
            end
        end
    end

    // Next-state logic: arbitration in IDLE, completion/abort in the grant states.
    always_comb begin
        state_d   = state_q;
        own_d     = own_q;
        rr_ptr_d  = rr_ptr_q;
        dstreak_d = dstreak_q;
`ifdef ARB_PERF_CNT_EN
        dgrant_cnt_d = dgrant_cnt_q;
        igrant_cnt_d = igrant_cnt_q;
        starve_cnt_d = starve_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (d_req_s) begin
                    if (any_i_s && (dstreak_q == STREAK_MAX_C)) begin
                        // Data has had its quota while a fetch waited: serve the fetch.
                        state_d = GNT_I;
                        own_d   = rr_pick_s;
`ifdef ARB_PERF_CNT_EN
                        starve_cnt_d = starve_cnt_q + 16'd1;
`endif
                    end else begin
                        state_d = GNT_D;
                    end
                end else if (any_i_s) begin
                    state_d = GNT_I;
                    own_d   = rr_pick_s;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT_D: begin
                if (!d_req_s) begin
                    state_d = IDLE;
                end else if (ram_access_s) begin
                    state_d = IDLE;
                    if (any_i_s) begin
                        if (dstreak_q < STREAK_MAX_C) begin
                            dstreak_d = dstreak_q + 4'd1;
                        end else begin
                            dstreak_d = dstreak_q;
                        end
                    end else begin
                        dstreak_d = 4'd0;
                    end
`ifdef ARB_PERF_CNT_EN
                    dgrant_cnt_d = dgrant_cnt_q + 32'd1;
`endif
                end else begin
                    state_d = GNT_D;
                end
            end
            GNT_I: begin
                if (!iREN[own_q]) begin
                    state_d = IDLE;
                end else if (ram_access_s) begin
                    state_d   = IDLE;
                    dstreak_d = 4'd0;
                    if (own_q == LAST_CPU_C) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = own_q + OW'(1);
                    end
`ifdef ARB_PERF_CNT_EN
                    igrant_cnt_d = igrant_cnt_q + 32'd1;
`endif
                end else begin
                    state_d = GNT_I;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            own_q     <= '0;
            rr_ptr_q  <= '0;
            dstreak_q <= 4'd0;
`ifdef ARB_PERF_CNT_EN
            dgrant_cnt_q <= 32'd0;
            igrant_cnt_q <= 32'd0;
            starve_cnt_q <= 16'd0;
`endif
        end else begin
            state_q   <= state_d;
            own_q     <= own_d;
            rr_ptr_q  <= rr_ptr_d;
            dstreak_q <= dstreak_d;
`ifdef ARB_PERF_CNT_EN
            dgrant_cnt_q <= dgrant_cnt_d;
            igrant_cnt_q <= igrant_cnt_d;
            starve_cnt_q <= starve_cnt_d;
`endif
        end
    end

`ifdef ARB_PERF_CNT_EN
    assign dgrant_cnt = dgrant_cnt_q;
    assign igrant_cnt = igrant_cnt_q;
    assign starve_cnt = starve_cnt_q;
`endif

    // Output steering: only the current owner sees the RAM; enables follow the
    // live request so an abort releases the RAM within the same cycle.
    always_comb begin
        iwait    = '1;
        iload    = '0;
        dwait    = 1'b1;
        dload    = 32'd0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        case (state_q)
            GNT_D: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dwait    = ~ram_access_s;
                if (ram_access_s) begin
                    dload = ramload;
                end else begin
                    dload = 32'd0;
                end
            end
            GNT_I: begin
                ramaddr       = iaddr[own_q];
                ramREN        = iREN[own_q];
                iwait[own_q]  = ~ram_access_s;
                if (ram_access_s) begin
                    iload[own_q] = ramload;
                end else begin
                    iload[own_q] = 32'd0;
                end
            end
            IDLE: begin
                ramREN = 1'b0;
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed-vector bench for ram_arbiter (CPUS=2, MAX_DSTREAK=4).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_ram_arbiter;

    logic              CLK;
    logic              RST;
    logic [1:0]        iREN;
    logic [1:0][31:0]  iaddr;
    logic [1:0]        iwait;
    logic [1:0][31:0]  iload;
    logic              dREN;
    logic              dWEN;
    logic [31:0]       daddr;
    logic [31:0]       dstore;
    logic              dwait;
    logic [31:0]       dload;
    logic              ramREN;
    logic              ramWEN;
    logic [31:0]       ramaddr;
    logic [31:0]       ramstore;
    logic [31:0]       ramload;
    logic [1:0]        ramstate;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]       dgrant_cnt;
    logic [31:0]       igrant_cnt;
    logic [15:0]       starve_cnt;
`endif

    int checks_q = 0;
    int errors_q = 0;

    ram_arbiter #(.CPUS(2), .MAX_DSTREAK(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
`ifdef ARB_PERF_CNT_EN
        ,
        .dgrant_cnt (dgrant_cnt),
        .igrant_cnt (igrant_cnt),
        .starve_cnt (starve_cnt)
`endif
    );

    // Free-running clock, period 10.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_q = checks_q + 1;
        if (got !== exp) begin
            errors_q = errors_q + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        iREN     = 2'b00;
        iaddr[0] = 32'h0000_0040;
        iaddr[1] = 32'h0000_0080;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = 32'h0000_0000;
        dstore   = 32'h0000_0000;
        ramload  = 32'h0000_0000;
        ramstate = 2'd0;
    endtask

    task automatic do_reset();
        clear_inputs();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        clear_inputs();

        // Reset then idle.
        tick();
        #1;
        chk("rst_iwait", {30'd0, iwait}, 32'h3);
        chk("rst_dwait", {31'd0, dwait}, 32'h1);
        chk("rst_ramREN", {31'd0, ramREN}, 32'h0);
        tick();
        RST = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("idle_iwait", {30'd0, iwait}, 32'h3);
            chk("idle_dwait", {31'd0, dwait}, 32'h1);
            chk("idle_en", {30'd0, ramREN, ramWEN}, 32'h0);
            chk("idle_addr", ramaddr, 32'h0);
            tick();
        end

        // Single fetch, two BUSY cycles then ACCESS.
        iREN     = 2'b01;
        ramstate = 2'd1;
        #1;
        chk("sf_idle_ren", {31'd0, ramREN}, 32'h0);
        for (int k = 0; k < 2; k++) begin
            tick();
            #1;
            chk("sf_busy_ren", {31'd0, ramREN}, 32'h1);
            chk("sf_busy_addr", ramaddr, 32'h40);
            chk("sf_busy_iwait", {30'd0, iwait}, 32'h3);
        end
        tick();
        ramstate = 2'd2;
        ramload  = 32'hDEAD_BEEF;
        #1;
        chk("sf_acc_ren", {31'd0, ramREN}, 32'h1);
        chk("sf_acc_addr", ramaddr, 32'h40);
        chk("sf_acc_iwait", {30'd0, iwait}, 32'h2);
        chk("sf_acc_iload0", iload[0], 32'hDEAD_BEEF);
        chk("sf_acc_iload1", iload[1], 32'h0);
        chk("sf_acc_dwait", {31'd0, dwait}, 32'h1);
        tick();
        iREN     = 2'b00;
        ramstate = 2'd0;
        #1;
        chk("sf_bubble_en", {30'd0, ramREN, ramWEN}, 32'h0);

        // Reset mid-access: rr_ptr is 1 here; reset must bring it back to 0.
        iREN     = 2'b10;
        ramstate = 2'd1;
        tick();
        #1;
        chk("rm_grant_addr", ramaddr, 32'h80);
        chk("rm_grant_ren", {31'd0, ramREN}, 32'h1);
        RST = 1'b1;
        tick();
        #1;
        chk("rm_after_ren", {31'd0, ramREN}, 32'h0);
        chk("rm_after_iwait", {30'd0, iwait}, 32'h3);
        RST      = 1'b0;
        iREN     = 2'b11;
        ramstate = 2'd2;
        tick();
        #1;
        chk("rm_rr0_iwait", {30'd0, iwait}, 32'h2);
        chk("rm_rr0_addr", ramaddr, 32'h40);

        // Round-robin with both fetches held and the RAM always ready.
        do_reset();
        iREN     = 2'b11;
        ramstate = 2'd2;
        ramload  = 32'h0000_1111;
        for (int k = 0; k < 4; k++) begin
            tick();
            #1;
            chk("rr_ren", {31'd0, ramREN}, 32'h1);
            chk("rr_iwait", {30'd0, iwait}, (k % 2 == 0) ? 32'h2 : 32'h1);
            chk("rr_addr", ramaddr, (k % 2 == 0) ? 32'h40 : 32'h80);
            tick();
            #1;
            chk("rr_bubble", {30'd0, ramREN, ramWEN}, 32'h0);
        end

        // Data priority and streak limit.
        do_reset();
        dREN     = 1'b1;
        daddr    = 32'h0000_0100;
        iREN     = 2'b10;
        ramstate = 2'd2;
        ramload  = 32'h1234_5678;
        for (int k = 0; k < 4; k++) begin
            tick();
            #1;
            chk("st_d_ren", {31'd0, ramREN}, 32'h1);
            chk("st_d_addr", ramaddr, 32'h100);
            chk("st_d_dwait", {31'd0, dwait}, 32'h0);
            chk("st_d_dload", dload, 32'h1234_5678);
            chk("st_d_iwait", {30'd0, iwait}, 32'h3);
            tick();
            #1;
            chk("st_d_bubble", {31'd0, ramREN}, 32'h0);
        end
        tick();
        #1;
        chk("st_i_addr", ramaddr, 32'h80);
        chk("st_i_iwait", {30'd0, iwait}, 32'h1);
        chk("st_i_dwait", {31'd0, dwait}, 32'h1);
        chk("st_i_iload1", iload[1], 32'h1234_5678);
`ifdef ARB_PERF_CNT_EN
        chk("st_starve_cnt", {16'd0, starve_cnt}, 32'h1);
`endif
        tick();
        #1;
        chk("st_i_bubble", {31'd0, ramREN}, 32'h0);
        tick();
        #1;
        chk("st_resume_addr", ramaddr, 32'h100);
        chk("st_resume_dwait", {31'd0, dwait}, 32'h0);

        // Write wins over read, then abort while BUSY.
        do_reset();
        dREN     = 1'b1;
        dWEN     = 1'b1;
        daddr    = 32'h0000_0100;
        dstore   = 32'h0000_0005;
        ramstate = 2'd1;
        tick();
        #1;
        chk("ww_wen", {31'd0, ramWEN}, 32'h1);
        chk("ww_ren", {31'd0, ramREN}, 32'h0);
        chk("ww_store", ramstore, 32'h5);
        chk("ww_addr", ramaddr, 32'h100);
        chk("ww_dwait", {31'd0, dwait}, 32'h1);
        tick();
        #1;
        chk("ww_hold_wen", {31'd0, ramWEN}, 32'h1);
        dREN = 1'b0;
        dWEN = 1'b0;
        #1;
        chk("ab_same_en", {30'd0, ramREN, ramWEN}, 32'h0);
        tick();
        dWEN = 1'b1;
        #1;
        chk("ab_idle_wen", {31'd0, ramWEN}, 32'h0);
        tick();
        #1;
        chk("ab_regrant_wen", {31'd0, ramWEN}, 32'h1);
        dWEN = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks_q, errors_q);
        $finish;
    end

endmodule
